// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU-to-memory arbiter: FSM encoding, request type
// and the index-width helper used by the arbiter and its round-robin picker.
package lsu_mem_arbiter_pkg;

   localparam int STATE_BITS = 3;

   typedef enum logic [STATE_BITS-1:0] {
      IDLE        = 3'd0,
      READ_WAIT   = 3'd1,
      WRITE_WAIT  = 3'd2,
      READ_RELAY  = 3'd3,
      WRITE_RELAY = 3'd4
   } state_t;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_type_t;

   // A single requester still needs a one-bit index so ports never collapse to zero width.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at or
// after the pointer, wrapping modulo the number of requesters.
module rr_pick
   import lsu_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   parameter int IDX_BITS       = idx_bits(NUM_REQUESTERS)
) (
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic [IDX_BITS-1:0]       pointer,
   output logic [IDX_BITS-1:0]       grant_index,
   output logic                      grant_valid
);

   localparam int CW = IDX_BITS + 1;

   logic [CW-1:0]       cand;
   logic [IDX_BITS-1:0] cand_idx;

   // One extra bit lets pointer+offset exceed N before the wrap subtraction.
   always_comb begin
      grant_index = '0;
      grant_valid = 1'b0;
      cand        = '0;
      cand_idx    = '0;
      for (int off = 0; off < NUM_REQUESTERS; off++) begin
         cand = {1'b0, pointer} + CW'(off);
         if (cand >= CW'(NUM_REQUESTERS)) begin
            cand = cand - CW'(NUM_REQUESTERS);
         end
         cand_idx = cand[IDX_BITS-1:0];
         if (!grant_valid && request[cand_idx]) begin
            grant_valid = 1'b1;
            grant_index = cand_idx;
         end
      end
   end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among the per-thread
// LSUs; one outstanding transaction, registered outputs, valid/ready on both sides.
module lsu_mem_arbiter
   import lsu_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4,
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQUESTERS-1:0]           req_read_valid,
   input  logic [NUM_REQUESTERS*ADDR_BITS-1:0] req_read_address,
   output logic [NUM_REQUESTERS-1:0]           req_read_ready,
   output logic [NUM_REQUESTERS*DATA_BITS-1:0] req_read_data,
   input  logic [NUM_REQUESTERS-1:0]           req_write_valid,
   input  logic [NUM_REQUESTERS*ADDR_BITS-1:0] req_write_address,
   input  logic [NUM_REQUESTERS*DATA_BITS-1:0] req_write_data,
   output logic [NUM_REQUESTERS-1:0]           req_write_ready,
   output logic                                mem_read_valid,
   output logic [ADDR_BITS-1:0]                mem_read_address,
   input  logic                                mem_read_ready,
   input  logic [DATA_BITS-1:0]                mem_read_data,
   output logic                                mem_write_valid,
   output logic [ADDR_BITS-1:0]                mem_write_address,
   output logic [DATA_BITS-1:0]                mem_write_data,
   input  logic                                mem_write_ready
);

   localparam int IDX_BITS = idx_bits(NUM_REQUESTERS);

   state_t              state, next_state;
   logic [IDX_BITS-1:0] rr_ptr, cur_idx, pick_idx;
   logic [IDX_BITS-1:0] nxt_rr_ptr, nxt_cur_idx, ptr_after_cur;
   logic                pick_valid, grant_ok;
   req_type_t           grant_type;

   logic [NUM_REQUESTERS-1:0]           nxt_req_read_ready, nxt_req_write_ready;
   logic [NUM_REQUESTERS*DATA_BITS-1:0] nxt_req_read_data;
   logic                                nxt_mem_read_valid, nxt_mem_write_valid;
   logic [ADDR_BITS-1:0]                nxt_mem_read_address, nxt_mem_write_address;
   logic [DATA_BITS-1:0]                nxt_mem_write_data;

   rr_pick #(
      .NUM_REQUESTERS(NUM_REQUESTERS),
      .IDX_BITS      (IDX_BITS)
   ) u_rr_pick (
      .request    (req_read_valid | req_write_valid),
      .pointer    (rr_ptr),
      .grant_index(pick_idx),
      .grant_valid(pick_valid)
   );

   // A lingering ready from the previous completion must not be mistaken for the next one.
   assign grant_ok      = pick_valid && !mem_read_ready && !mem_write_ready;
   assign grant_type    = req_read_valid[pick_idx] ? REQ_READ : REQ_WRITE;
   assign ptr_after_cur = (cur_idx == IDX_BITS'(NUM_REQUESTERS - 1)) ? '0 : cur_idx + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         rr_ptr            <= '0;
         cur_idx           <= '0;
         req_read_ready    <= '0;
         req_write_ready   <= '0;
         req_read_data     <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
      end else begin
         state             <= next_state;
         rr_ptr            <= nxt_rr_ptr;
         cur_idx           <= nxt_cur_idx;
         req_read_ready    <= nxt_req_read_ready;
         req_write_ready   <= nxt_req_write_ready;
         req_read_data     <= nxt_req_read_data;
         mem_read_valid    <= nxt_mem_read_valid;
         mem_read_address  <= nxt_mem_read_address;
         mem_write_valid   <= nxt_mem_write_valid;
         mem_write_address <= nxt_mem_write_address;
         mem_write_data    <= nxt_mem_write_data;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_ok) begin
               next_state = (grant_type == REQ_READ) ? READ_WAIT : WRITE_WAIT;
            end
         end
         READ_WAIT:   if (mem_read_ready)            next_state = READ_RELAY;
         WRITE_WAIT:  if (mem_write_ready)           next_state = WRITE_RELAY;
         READ_RELAY:  if (!req_read_valid[cur_idx])  next_state = IDLE;
         WRITE_RELAY: if (!req_write_valid[cur_idx]) next_state = IDLE;
         default:                                    next_state = IDLE;
      endcase
   end

   // Everything holds by default; addresses and write data are only captured at grant.
   always_comb begin
      nxt_rr_ptr            = rr_ptr;
      nxt_cur_idx           = cur_idx;
      nxt_req_read_ready    = req_read_ready;
      nxt_req_write_ready   = req_write_ready;
      nxt_req_read_data     = req_read_data;
      nxt_mem_read_valid    = mem_read_valid;
      nxt_mem_read_address  = mem_read_address;
      nxt_mem_write_valid   = mem_write_valid;
      nxt_mem_write_address = mem_write_address;
      nxt_mem_write_data    = mem_write_data;
      case (state)
         IDLE: begin
            if (grant_ok) begin
               nxt_cur_idx = pick_idx;
               if (grant_type == REQ_READ) begin
                  nxt_mem_read_valid   = 1'b1;
                  nxt_mem_read_address = req_read_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
               end else begin
                  nxt_mem_write_valid   = 1'b1;
                  nxt_mem_write_address = req_write_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
                  nxt_mem_write_data    = req_write_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
               end
            end
         end
         READ_WAIT: begin
            if (mem_read_ready) begin
               nxt_mem_read_valid = 1'b0;
               nxt_req_read_ready[cur_idx] = 1'b1;
               nxt_req_read_data[int'(cur_idx)*DATA_BITS +: DATA_BITS] = mem_read_data;
            end
         end
         WRITE_WAIT: begin
            if (mem_write_ready) begin
               nxt_mem_write_valid = 1'b0;
               nxt_req_write_ready[cur_idx] = 1'b1;
            end
         end
         READ_RELAY: begin
            if (!req_read_valid[cur_idx]) begin
               nxt_req_read_ready[cur_idx] = 1'b0;
               nxt_rr_ptr = ptr_after_cur;
            end
         end
         WRITE_RELAY: begin
            if (!req_write_valid[cur_idx]) begin
               nxt_req_write_ready[cur_idx] = 1'b0;
               nxt_rr_ptr = ptr_after_cur;
            end
         end
         default: begin
            nxt_req_read_ready  = '0;
            nxt_req_write_ready = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed testbench for lsu_mem_arbiter: the bench plays both the LSUs and
// the memory controller, with hand-computed expectations per scenario.
module tb_lsu_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_read_valid;
   logic [N*AW-1:0] req_read_address;
   logic [N-1:0]    req_read_ready;
   logic [N*DW-1:0] req_read_data;
   logic [N-1:0]    req_write_valid;
   logic [N*AW-1:0] req_write_address;
   logic [N*DW-1:0] req_write_data;
   logic [N-1:0]    req_write_ready;
   logic            mem_read_valid;
   logic [AW-1:0]   mem_read_address;
   logic            mem_read_ready;
   logic [DW-1:0]   mem_read_data;
   logic            mem_write_valid;
   logic [AW-1:0]   mem_write_address;
   logic [DW-1:0]   mem_write_data;
   logic            mem_write_ready;

   int vectors;
   int miscompares;

   lsu_mem_arbiter #(
      .NUM_REQUESTERS(N),
      .ADDR_BITS     (AW),
      .DATA_BITS     (DW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_read_valid   (req_read_valid),
      .req_read_address (req_read_address),
      .req_read_ready   (req_read_ready),
      .req_read_data    (req_read_data),
      .req_write_valid  (req_write_valid),
      .req_write_address(req_write_address),
      .req_write_data   (req_write_data),
      .req_write_ready  (req_write_ready),
      .mem_read_valid   (mem_read_valid),
      .mem_read_address (mem_read_address),
      .mem_read_ready   (mem_read_ready),
      .mem_read_data    (mem_read_data),
      .mem_write_valid  (mem_write_valid),
      .mem_write_address(mem_write_address),
      .mem_write_data   (mem_write_data),
      .mem_write_ready  (mem_write_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset             = 1'b0;
      req_read_valid    = '0;
      req_read_address  = '0;
      req_write_valid   = '0;
      req_write_address = '0;
      req_write_data    = '0;
      mem_read_ready    = 1'b0;
      mem_read_data     = '0;
      mem_write_ready   = 1'b0;
      tick();
      tick();
      vectors++;
      if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
           req_read_ready, req_write_ready, req_read_data} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got rv=%b wv=%b ra=%h wa=%h wd=%h rr=%b wr=%b rd=%h, expected all 0",
                  mem_read_valid, mem_write_valid, mem_read_address, mem_write_address,
                  mem_write_data, req_read_ready, req_write_ready, req_read_data);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      req_read_valid[2]       = 1'b1;
      req_read_address[16+:8] = 8'h10;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin
         miscompares++;
         $display("[TB] FAIL read_grant: got valid=%b addr=%h, expected valid=1 addr=10",
                  mem_read_valid, mem_read_address);
      end
      mem_read_data  = 8'hA5;
      mem_read_ready = 1'b1;
      tick();
      mem_read_ready = 1'b0;
      vectors++;
      if (req_read_ready !== 4'b0100 || req_read_data[16+:8] !== 8'hA5 || mem_read_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL read_done: got ready=%b data=%h mvalid=%b, expected ready=0100 data=a5 mvalid=0",
                  req_read_ready, req_read_data[16+:8], mem_read_valid);
      end
      tick();
      vectors++;
      if (req_read_ready !== 4'b0100) begin
         miscompares++;
         $display("[TB] FAIL read_ready_hold: got %b, expected 0100", req_read_ready);
      end
      req_read_valid[2] = 1'b0;
      tick();
      vectors++;
      if (req_read_ready !== 4'b0000 || req_read_data[16+:8] !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL read_release: got ready=%b data=%h, expected ready=0000 data=a5",
                  req_read_ready, req_read_data[16+:8]);
      end
   endtask

   task automatic test_single_write();
      req_write_valid[1]       = 1'b1;
      req_write_address[8+:8]  = 8'h20;
      req_write_data[8+:8]     = 8'h3C;
      tick();
      vectors++;
      if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h20 || mem_write_data !== 8'h3C
          || mem_read_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL write_grant: got wv=%b wa=%h wd=%h rv=%b, expected wv=1 wa=20 wd=3c rv=0",
                  mem_write_valid, mem_write_address, mem_write_data, mem_read_valid);
      end
      req_write_address[8+:8] = 8'h99;
      req_write_data[8+:8]    = 8'h77;
      tick();
      vectors++;
      if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h20 || mem_write_data !== 8'h3C) begin
         miscompares++;
         $display("[TB] FAIL write_wait_hold: got wv=%b wa=%h wd=%h, expected wv=1 wa=20 wd=3c",
                  mem_write_valid, mem_write_address, mem_write_data);
      end
      mem_write_ready = 1'b1;
      tick();
      mem_write_ready = 1'b0;
      vectors++;
      if (req_write_ready !== 4'b0010 || mem_write_valid !== 1'b0 || req_read_ready !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL write_done: got wr=%b wv=%b rr=%b, expected wr=0010 wv=0 rr=0000",
                  req_write_ready, mem_write_valid, req_read_ready);
      end
      req_write_valid[1] = 1'b0;
      tick();
      vectors++;
      if (req_write_ready !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL write_release: got %b, expected 0000", req_write_ready);
      end
   endtask

   task automatic test_contention();
      int            order [5] = '{0, 1, 2, 3, 0};
      int            exp_i;
      int            w;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      logic [N-1:0]  exp_ready;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         req_read_address[i*AW +: AW] = 8'h40 + 8'(i);
      end
      req_read_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_i     = order[k];
         exp_addr  = 8'h40 + 8'(exp_i);
         exp_data  = 8'h80 + 8'(exp_i);
         exp_ready = 4'(1 << exp_i);
         w = 0;
         while (mem_read_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
         end
         vectors++;
         if (mem_read_valid !== 1'b1 || mem_read_address !== exp_addr) begin
            miscompares++;
            $display("[TB] FAIL contention_grant[%0d]: got valid=%b addr=%h, expected valid=1 addr=%h",
                     k, mem_read_valid, mem_read_address, exp_addr);
         end
         mem_read_data  = exp_data;
         mem_read_ready = 1'b1;
         tick();
         mem_read_ready = 1'b0;
         vectors++;
         if (req_read_ready !== exp_ready || req_read_data[exp_i*DW +: DW] !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL contention_done[%0d]: got ready=%b data=%h, expected ready=%b data=%h",
                     k, req_read_ready, req_read_data[exp_i*DW +: DW], exp_ready, exp_data);
         end
         req_read_valid[exp_i] = 1'b0;
         tick();
         if (k == 0) req_read_valid[0] = 1'b1;
      end
      vectors++;
      if (req_read_ready !== 4'b0000 || mem_read_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL contention_end: got ready=%b mvalid=%b, expected ready=0000 mvalid=0",
                  req_read_ready, mem_read_valid);
      end
   endtask

   task automatic test_read_write_tie();
      int w;
      req_read_address[0+:8]  = 8'h55;
      req_write_address[0+:8] = 8'h66;
      req_write_data[0+:8]    = 8'h5A;
      req_read_valid[0]       = 1'b1;
      req_write_valid[0]      = 1'b1;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== 8'h55) begin
         miscompares++;
         $display("[TB] FAIL tie_read_first: got rv=%b wv=%b ra=%h, expected rv=1 wv=0 ra=55",
                  mem_read_valid, mem_write_valid, mem_read_address);
      end
      mem_read_data  = 8'h11;
      mem_read_ready = 1'b1;
      tick();
      mem_read_ready = 1'b0;
      vectors++;
      if (req_read_ready !== 4'b0001 || req_write_ready !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL tie_read_done: got rr=%b wr=%b, expected rr=0001 wr=0000",
                  req_read_ready, req_write_ready);
      end
      req_read_valid[0] = 1'b0;
      tick();
      w = 0;
      while (mem_write_valid !== 1'b1 && w < 8) begin
         tick();
         w++;
      end
      vectors++;
      if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h66 || mem_write_data !== 8'h5A
          || mem_read_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL tie_write_next: got wv=%b wa=%h wd=%h rv=%b, expected wv=1 wa=66 wd=5a rv=0",
                  mem_write_valid, mem_write_address, mem_write_data, mem_read_valid);
      end
      mem_write_ready = 1'b1;
      tick();
      mem_write_ready = 1'b0;
      vectors++;
      if (req_write_ready !== 4'b0001) begin
         miscompares++;
         $display("[TB] FAIL tie_write_done: got %b, expected 0001", req_write_ready);
      end
      req_write_valid[0] = 1'b0;
      tick();
   endtask

   task automatic test_stale_ready();
      req_read_address[24+:8] = 8'h70;
      req_read_valid[3]       = 1'b1;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h70) begin
         miscompares++;
         $display("[TB] FAIL stale_first_grant: got valid=%b addr=%h, expected valid=1 addr=70",
                  mem_read_valid, mem_read_address);
      end
      mem_read_data  = 8'h33;
      mem_read_ready = 1'b1;
      tick();
      vectors++;
      if (req_read_ready !== 4'b1000) begin
         miscompares++;
         $display("[TB] FAIL stale_first_done: got %b, expected 1000", req_read_ready);
      end
      req_read_valid[3]       = 1'b0;
      req_read_address[8+:8]  = 8'h71;
      req_read_valid[1]       = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         vectors++;
         if (mem_read_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stale_no_grant[%0d]: got mem_read_valid=%b, expected 0", r, mem_read_valid);
         end
      end
      mem_read_ready = 1'b0;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h71) begin
         miscompares++;
         $display("[TB] FAIL stale_late_grant: got valid=%b addr=%h, expected valid=1 addr=71",
                  mem_read_valid, mem_read_address);
      end
      mem_read_data  = 8'h44;
      mem_read_ready = 1'b1;
      tick();
      mem_read_ready = 1'b0;
      vectors++;
      if (req_read_ready !== 4'b0010 || req_read_data[8+:8] !== 8'h44) begin
         miscompares++;
         $display("[TB] FAIL stale_second_done: got ready=%b data=%h, expected ready=0010 data=44",
                  req_read_ready, req_read_data[8+:8]);
      end
      req_read_valid[1] = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      req_read_address[16+:8] = 8'h2A;
      req_read_valid[2]       = 1'b1;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h2A) begin
         miscompares++;
         $display("[TB] FAIL midreset_grant: got valid=%b addr=%h, expected valid=1 addr=2a",
                  mem_read_valid, mem_read_address);
      end
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data,
           req_read_ready, req_write_ready, req_read_data} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midreset_async: got rv=%b ra=%h wv=%b rr=%b wr=%b rd=%h, expected all 0",
                  mem_read_valid, mem_read_address, mem_write_valid, req_read_ready,
                  req_write_ready, req_read_data);
      end
      req_read_valid[2] = 1'b0;
      tick();
      reset = 1'b1;
      req_read_address[8+:8]  = 8'h31;
      req_read_address[24+:8] = 8'h33;
      req_read_valid          = 4'b1010;
      tick();
      vectors++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h31) begin
         miscompares++;
         $display("[TB] FAIL midreset_ptr_zero: got valid=%b addr=%h, expected valid=1 addr=31",
                  mem_read_valid, mem_read_address);
      end
      mem_read_data  = 8'h99;
      mem_read_ready = 1'b1;
      tick();
      mem_read_ready = 1'b0;
      vectors++;
      if (req_read_ready !== 4'b0010 || req_read_data[8+:8] !== 8'h99) begin
         miscompares++;
         $display("[TB] FAIL midreset_fresh_done: got ready=%b data=%h, expected ready=0010 data=99",
                  req_read_ready, req_read_data[8+:8]);
      end
      req_read_valid = 4'b0000;
      tick();
      vectors++;
      if (req_read_ready !== 4'b0000 || mem_read_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_release: got ready=%b mvalid=%b, expected ready=0000 mvalid=0",
                  req_read_ready, mem_read_valid);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_read_write_tie();
      test_stale_ready();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
